demux4_reg: RTL and testbench
=============================

DEMUX4_REG -- requirements
Module: demux4_reg

Interface
REQ-001 Parameter: WIDTH, default 8, data width of every payload port.
REQ-002 The block SHALL have one clock, clk, and an asynchronous, active-low reset, rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream presents a word.
REQ-006 in_ready  output  1  block accepts the word this cycle.
REQ-007 in_data  input  WIDTH  payload.
REQ-008 in_sel  input  2  destination index 0..3.
REQ-009 out_valid  output  4  bit i: slot i holds a word.
REQ-010 out_ready  input  4  bit i: consumer i takes slot i's word this cycle.
REQ-011 out_data0, out_data1, out_data2, out_data3  output  WIDTH each  slot payloads.
REQ-012 stall_cnt  output  16  count of blocked input cycles (see Configuration).

Function
REQ-013 The block SHALL hold one register slot per destination: slot i comprises out_valid[i] and out_data<i>.
REQ-014 A transfer in SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-015 A transfer out of slot i SHALL occur on a rising edge where out_valid[i]=1 and out_ready[i]=1.
REQ-016 in_ready SHALL be combinational: in_ready = !out_valid[in_sel] | out_ready[in_sel].
REQ-017 in_ready SHALL NOT depend on in_valid.
REQ-018 On a transfer in, slot in_sel SHALL load in_data and set its valid bit on that edge, giving 1-cycle latency to out_valid.
REQ-019 Slots other than in_sel SHALL be unaffected by a transfer in.
REQ-020 On a transfer out with no refill of the same slot, out_valid[i] SHALL clear on that edge.
REQ-021 Simultaneous drain and refill of the same slot SHALL keep out_valid[i]=1 and load the new data, with no bubble.
REQ-022 out_data<i> SHALL hold its value while out_valid[i]=1 and out_ready[i]=0.
REQ-023 out_data<i> SHALL hold its value while the slot is empty.
REQ-024 Any number of slots SHALL drain in the same cycle, independently of each other.
REQ-025 Words to the same destination SHALL leave in arrival order; nothing is dropped or duplicated.
REQ-026 in_sel and in_data SHALL be ignored when in_valid=0.
REQ-027 The slot state machine SHALL have two states per slot.
- EMPTY -> FULL on a transfer in.
- FULL -> EMPTY on a transfer out without refill.
- FULL -> FULL on drain plus refill.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately clear out_valid to 4'b0000, independent of clk.
REQ-029 Asserting rst_n=0 SHALL immediately clear out_data0..3 to all-zero and stall_cnt to 0, independent of clk.
REQ-030 Reset mid-operation SHALL discard all held words.
REQ-031 After deassertion, the first transfer SHALL be possible on the first rising edge.

Configuration
REQ-032 Macro DEMUX4_REG_STALL_CNT_EN SHALL select the stall counter.
REQ-033 Macro defined: stall_cnt SHALL increment by 1 on every edge where in_valid=1 and in_ready=0.
REQ-034 Macro defined: stall_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-035 Macro undefined: stall_cnt SHALL be constant 0 and no counter flops SHALL exist.
REQ-036 The port list SHALL be identical in both builds.

Verification
REQ-037 Single route: in_data=8'hA5, in_sel=2, out_ready=4'b0000 -> next cycle out_valid=4'b0100 and out_data2=8'hA5; other slots stay empty.
REQ-038 Backpressure: slot 1 full, out_ready[1]=0, in_sel=1, in_valid=1 -> in_ready=0, slot 1 keeps its old word; with the macro, stall_cnt increments each cycle (3 cycles -> 3).
REQ-039 Drain+refill: slot 0 holds 8'h11, out_ready[0]=1, input 8'h22 to sel 0 -> in_ready=1, out_valid[0] stays 1, out_data0=8'h22 next cycle.
REQ-040 Parallel: all four slots full, out_ready=4'b1111, in_valid=0 -> out_valid=4'b0000 after one edge.
REQ-041 Async reset: slots 0 and 3 full, rst_n pulled low between edges -> out_valid=0 and out_data=0 before the next edge; first post-reset input accepted.
REQ-042 Saturation (macro defined): hold the blocked condition for 65540 cycles -> stall_cnt=16'hFFFF; macro undefined -> stall_cnt=0 throughout.

Source files
------------

// File: rtl/demux4_reg.sv
// demux4_reg: routes one input word to one of four registered output slots.
// Each slot is a one-deep holding register with its own valid/ready handshake,
// so a slot can drain and refill on the same edge without a bubble.
// Optional build macro DEMUX4_REG_STALL_CNT_EN adds a saturating 16-bit counter
// of cycles where the input was offered but blocked; without it stall_cnt is 0.
module demux4_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [15:0]      stall_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t      state_q [4];
  slot_state_t      state_d [4];
  logic [WIDTH-1:0] data_q  [4];
  logic [3:0]       load;

  // Slot valid bits are simply the slot states viewed as a vector
  always_comb begin
    out_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      out_valid[i] = (state_q[i] == FULL);
    end
  end

  // The selected slot can take a word if it is empty or being drained this cycle
  always_comb begin
    in_ready = !out_valid[in_sel] || out_ready[in_sel];
  end

  // Per-slot next-state logic; a drain with a simultaneous refill stays FULL
  always_comb begin
    load = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      load[i]    = in_valid && in_ready && (in_sel == 2'(i));
      case (state_q[i])
        EMPTY: begin
          if (load[i]) state_d[i] = FULL;
        end
        FULL: begin
          if (out_ready[i] && !load[i]) state_d[i] = EMPTY;
        end
        default: state_d[i] = EMPTY;
      endcase
    end
  end

  // Slot state and payload registers; payload only changes when a word is loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        if (load[i]) data_q[i] <= in_data;
      end
    end
  end

  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];

`ifdef DEMUX4_REG_STALL_CNT_EN
  logic [15:0] stall_q;

  // Count offered-but-blocked input cycles, sticking at the maximum value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'h0000;
    end else if (in_valid && !in_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_demux4_reg.sv
// tb_demux4_reg: directed, table-driven bench for demux4_reg plus hand-written
// sequences for backpressure, parallel drain, async reset and counter saturation.
// Honours DEMUX4_REG_STALL_CNT_EN to pick the expected stall_cnt behaviour.
module tb_demux4_reg;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;
  logic [15:0]      stall_cnt;

  int num_checks;
  int num_fails;

  typedef struct {
    logic             iv;
    logic [1:0]       sel;
    logic [WIDTH-1:0] data;
    logic [3:0]       ordy;
    logic             exp_rdy;
    logic [3:0]       exp_valid;
    logic [WIDTH-1:0] exp_d0;
    logic [WIDTH-1:0] exp_d1;
    logic [WIDTH-1:0] exp_d2;
    logic [WIDTH-1:0] exp_d3;
  } vec_t;

  vec_t vectors [11];

  demux4_reg #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .stall_cnt (stall_cnt)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic iv, input logic [1:0] sel,
                               input logic [WIDTH-1:0] data, input logic [3:0] ordy);
    in_valid  = iv;
    in_sel    = sel;
    in_data   = data;
    out_ready = ordy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkSlots(input string tag, input logic [3:0] ev,
                            input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                            input logic [WIDTH-1:0] e2, input logic [WIDTH-1:0] e3);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'(ev));
    checkOutput({tag, " out_data0"}, 32'(out_data0), 32'(e0));
    checkOutput({tag, " out_data1"}, 32'(out_data1), 32'(e1));
    checkOutput({tag, " out_data2"}, 32'(out_data2), 32'(e2));
    checkOutput({tag, " out_data3"}, 32'(out_data3), 32'(e3));
  endtask

  task automatic doReset();
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Push one word into an empty slot with no consumers ready
  task automatic fillSlot(input logic [1:0] sel, input logic [WIDTH-1:0] data);
    applyStimulus(1'b1, sel, data, 4'b0000);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    num_checks = 0;
    num_fails  = 0;
    rst_n      = 1'b0;
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);

    //                 iv    sel   data   ordy     rdy   valid    d0     d1     d2     d3
    vectors[0]  = '{1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00};
    vectors[1]  = '{1'b1, 2'd0, 8'h11, 4'b0000, 1'b1, 4'b0101, 8'h11, 8'h00, 8'hA5, 8'h00};
    vectors[2]  = '{1'b1, 2'd2, 8'h77, 4'b0000, 1'b0, 4'b0101, 8'h11, 8'h00, 8'hA5, 8'h00};
    vectors[3]  = '{1'b1, 2'd0, 8'h22, 4'b0001, 1'b1, 4'b0101, 8'h22, 8'h00, 8'hA5, 8'h00};
    vectors[4]  = '{1'b0, 2'd1, 8'hFF, 4'b0100, 1'b1, 4'b0001, 8'h22, 8'h00, 8'hA5, 8'h00};
    vectors[5]  = '{1'b1, 2'd1, 8'h3C, 4'b0000, 1'b1, 4'b0011, 8'h22, 8'h3C, 8'hA5, 8'h00};
    vectors[6]  = '{1'b1, 2'd3, 8'hC3, 4'b0010, 1'b1, 4'b1001, 8'h22, 8'h3C, 8'hA5, 8'hC3};
    vectors[7]  = '{1'b0, 2'd3, 8'h00, 4'b0000, 1'b0, 4'b1001, 8'h22, 8'h3C, 8'hA5, 8'hC3};
    vectors[8]  = '{1'b1, 2'd2, 8'h5A, 4'b1001, 1'b1, 4'b0100, 8'h22, 8'h3C, 8'h5A, 8'hC3};
    vectors[9]  = '{1'b1, 2'd2, 8'h6B, 4'b0100, 1'b1, 4'b0100, 8'h22, 8'h3C, 8'h6B, 8'hC3};
    vectors[10] = '{1'b0, 2'd0, 8'h00, 4'b0100, 1'b1, 4'b0000, 8'h22, 8'h3C, 8'h6B, 8'hC3};

    // Reset state while reset is held
    #12;
    checkSlots("reset", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("reset stall_cnt", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vectors[i].iv, vectors[i].sel, vectors[i].data, vectors[i].ordy);
      #1;
      checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vectors[i].exp_rdy));
      @(posedge clk);
      @(negedge clk);
      checkSlots($sformatf("vec%0d", i), vectors[i].exp_valid, vectors[i].exp_d0,
                 vectors[i].exp_d1, vectors[i].exp_d2, vectors[i].exp_d3);
    end
`ifdef DEMUX4_REG_STALL_CNT_EN
    checkOutput("table stall_cnt", 32'(stall_cnt), 32'd1);
`else
    checkOutput("table stall_cnt", 32'(stall_cnt), 32'd0);
`endif

    // Backpressure: slot 1 full and not draining, three blocked cycles
    doReset();
    fillSlot(2'd1, 8'h44);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 2'd1, 8'h99, 4'b0000);
      #1;
      checkOutput($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      checkSlots($sformatf("bp%0d", c), 4'b0010, 8'h00, 8'h44, 8'h00, 8'h00);
    end
`ifdef DEMUX4_REG_STALL_CNT_EN
    checkOutput("bp stall_cnt", 32'(stall_cnt), 32'd3);
`else
    checkOutput("bp stall_cnt", 32'(stall_cnt), 32'd0);
`endif

    // Parallel drain of all four slots on one edge
    doReset();
    fillSlot(2'd0, 8'h01);
    fillSlot(2'd1, 8'h02);
    fillSlot(2'd2, 8'h03);
    fillSlot(2'd3, 8'h04);
    checkSlots("par fill", 4'b1111, 8'h01, 8'h02, 8'h03, 8'h04);
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111);
    @(posedge clk);
    @(negedge clk);
    checkSlots("par drain", 4'b0000, 8'h01, 8'h02, 8'h03, 8'h04);

    // Async reset between edges, then first post-reset word accepted
    doReset();
    fillSlot(2'd0, 8'hE0);
    fillSlot(2'd3, 8'hE3);
    applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    checkSlots("arst", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("arst stall_cnt", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 2'd1, 8'h81, 4'b0000);
    #1;
    checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    checkSlots("post-reset", 4'b0010, 8'h00, 8'h81, 8'h00, 8'h00);

    // Stall counter saturation (or constant zero without the counter)
    doReset();
    fillSlot(2'd0, 8'h55);
    applyStimulus(1'b1, 2'd0, 8'h66, 4'b0000);
`ifdef DEMUX4_REG_STALL_CNT_EN
    for (int c = 0; c < 65540; c++) begin
      @(posedge clk);
    end
    @(negedge clk);
    checkOutput("sat stall_cnt", 32'(stall_cnt), 32'h0000FFFF);
`else
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("nocnt%0d stall_cnt", c), 32'(stall_cnt), 32'h0);
    end
`endif
    checkSlots("sat hold", 4'b0001, 8'h55, 8'h00, 8'h00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
